// File: rtl/sysarray_pkg.sv
// Shared types and constants for the Givens-rotation QR systolic array.
package sysarray_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    HOLD
  } pe_state_t;

  localparam real C_IDENTITY     = 1.0;
  localparam real S_IDENTITY     = 0.0;
  localparam int  PE_LATENCY_DEF = 4;

endpackage

// File: rtl/pe_givens_calc.sv
// Combinational Givens rotation: annihilate x against rp, give (c, s, r_new).
module pe_givens_calc
  import sysarray_pkg::*;
(
  input  real i_rp,
  input  real i_x,
  output real o_c,
  output real o_s,
  output real o_r
);

  real w_rr;
  real w_rt;

  always_comb begin
    w_rr = i_rp * i_rp + i_x * i_x;
    w_rt = 0.0;
    o_c  = C_IDENTITY;
    o_s  = S_IDENTITY;
    o_r  = 0.0;
    // a zero vector has no direction: fall back to the identity rotation
    if (w_rr != 0.0) begin
      w_rt = $sqrt(w_rr);
      o_c  = i_rp / w_rt;
      o_s  = i_x / w_rt;
      o_r  = w_rt;
    end
  end

endmodule

// File: rtl/pe_boundary.sv
// Boundary (diagonal) cell of the QR systolic array; fixed-latency Givens unit.
// Define PE_BOUNDARY_FORGET_EN to scale r by LAMBDA before each update (RLS).
module pe_boundary
  import sysarray_pkg::*;
#(
  parameter int  LATENCY = PE_LATENCY_DEF,
  parameter real LAMBDA  = 0.99
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  real  x_in,
  input  logic in_valid,
  output logic in_ready,
  output real  c_out,
  output real  s_out,
  output logic out_valid,
  input  logic out_ready,
  output real  r_out
);

  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;

  if (LATENCY < 1 || LAMBDA <= 0.0 || LAMBDA > 1.0) begin : g_bad_cfg
    $error("pe_boundary: need LATENCY >= 1 and LAMBDA in (0,1]");
  end

  pe_state_t     r_state;
  logic [CW-1:0] r_cnt;
  real           r_r;
  real           r_c_p;
  real           r_s_p;
  real           r_r_p;
  real           r_c;
  real           r_s;
  logic          r_valid;

  real  w_rp;
  real  w_c;
  real  w_s;
  real  w_r_new;
  logic w_accept;

`ifdef PE_BOUNDARY_FORGET_EN
  assign w_rp = LAMBDA * r_r;
`else
  assign w_rp = r_r;
`endif

  pe_givens_calc u_calc (
    .i_rp (w_rp),
    .i_x  (x_in),
    .o_c  (w_c),
    .o_s  (w_s),
    .o_r  (w_r_new)
  );

  assign in_ready = !clr &&
                    (r_state == IDLE ||
                     (r_state == HOLD && out_ready));
  assign w_accept = in_valid && in_ready;

  assign c_out     = r_c;
  assign s_out     = r_s;
  assign r_out     = r_r;
  assign out_valid = r_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_r     <= 0.0;
      r_c_p   <= C_IDENTITY;
      r_s_p   <= S_IDENTITY;
      r_r_p   <= 0.0;
      r_c     <= C_IDENTITY;
      r_s     <= S_IDENTITY;
      r_valid <= 1'b0;
    end else if (clr) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_r     <= 0.0;
      r_c     <= C_IDENTITY;
      r_s     <= S_IDENTITY;
      r_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE, HOLD: begin
          if (w_accept) begin
            if (LATENCY == 1) begin
              r_state <= HOLD;
              r_r     <= w_r_new;
              r_c     <= w_c;
              r_s     <= w_s;
              r_valid <= 1'b1;
            end else begin
              r_state <= BUSY;
              r_cnt   <= CW'(LATENCY - 2);
              r_c_p   <= w_c;
              r_s_p   <= w_s;
              r_r_p   <= w_r_new;
              r_c     <= C_IDENTITY;
              r_s     <= S_IDENTITY;
              r_valid <= 1'b0;
            end
          end else if (r_state == HOLD && out_ready) begin
            r_state <= IDLE;
            r_c     <= C_IDENTITY;
            r_s     <= S_IDENTITY;
            r_valid <= 1'b0;
          end
        end
        BUSY: begin
          if (r_cnt == '0) begin
            r_state <= HOLD;
            r_r     <= r_r_p;
            r_c     <= r_c_p;
            r_s     <= r_s_p;
            r_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_boundary.sv
// Self-checking bench for pe_boundary: directed cases plus random traffic
// compared every cycle against a transaction-level model of the cell.
module tb_pe_boundary;

  localparam int  LAT = 4;
  localparam real LAM = 0.5;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  real  x_in;
  real  c_out;
  real  s_out;
  real  r_out;

  pe_boundary #(
    .LATENCY (LAT),
    .LAMBDA  (LAM)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .x_in      (x_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .c_out     (c_out),
    .s_out     (s_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r_out     (r_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // model: stored r, presented result, and one pending result with due cycle
  real mr, mc, ms, pc, ps, pr;
  bit  mv, pend;
  int  due;

  function automatic void givens(input real r, input real x,
                                 output real c, output real s,
                                 output real rn);
    real rp, h;
`ifdef PE_BOUNDARY_FORGET_EN
    rp = LAM * r;
`else
    rp = r;
`endif
    h = rp * rp + x * x;
    if (h == 0.0) begin
      c = 1.0; s = 0.0; rn = 0.0;
    end else begin
      rn = $sqrt(h); c = rp / rn; s = x / rn;
    end
  endfunction

  function bit m_ready();
    return !clr && !pend && (!mv || out_ready);
  endfunction

  task automatic model_reset();
    mr = 0.0; mc = 1.0; ms = 0.0;
    mv = 1'b0; pend = 1'b0; due = 0;
  endtask

  // result becomes visible LAT cycles after the cycle the input was taken
  task automatic model_edge();
    bit acc;
    cyc++;
    acc = in_valid && m_ready();
    if (clr) begin
      mr = 0.0; mv = 1'b0; pend = 1'b0;
    end else begin
      if (mv && out_ready) mv = 1'b0;
      if (acc) begin
        givens(mr, x_in, pc, ps, pr);
        pend = 1'b1;
        due  = cyc + LAT - 1;
      end
      if (pend && cyc == due) begin
        mv = 1'b1; mc = pc; ms = ps; mr = pr; pend = 1'b0;
      end
    end
  endtask

  task automatic chk_bit(input string n, input logic a, input logic e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%b want=%b", n, cyc, a, e);
    end
  endtask

  task automatic chk_real(input string n, input real a, input real e);
    total++;
    if (!((a - e) < 1e-6 && (e - a) < 1e-6)) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%f want=%f", n, cyc, a, e);
    end
  endtask

  task automatic check_all();
    chk_bit("out_valid", out_valid, mv);
    chk_bit("in_ready", in_ready, m_ready());
    chk_real("c_out", c_out, mv ? mc : 1.0);
    chk_real("s_out", s_out, mv ? ms : 0.0);
    chk_real("r_out", r_out, mr);
  endtask

  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    #3;
    clr = 1'b0;
    rst = 1'b1;
    #1;
    chk_real("rst_c", c_out, 1.0);
    chk_real("rst_s", s_out, 0.0);
    chk_real("rst_r", r_out, 0.0);
    chk_bit("rst_valid", out_valid, 1'b0);
    chk_bit("rst_ready", in_ready, 1'b1);
    model_reset();
    #1;
    rst = 1'b0;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic send(input real x);
    int n = 0;
    in_valid = 1'b1;
    x_in = x;
    while (!m_ready() && n < 20) begin
      cycle(); n++;
    end
    if (n == 20) begin
      total++; bad++;
      $display("FAIL send_timeout cyc=%0d got=blocked want=accept", cyc);
    end
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!mv && n < 20) begin
      cycle(); n++;
    end
    if (n == 20) begin
      total++; bad++;
      $display("FAIL wait_timeout cyc=%0d got=no_result want=result", cyc);
    end
  endtask

  task automatic clear_r();
    clr = 1'b1;
    cycle();
    clr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=hang want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; clr = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1; x_in = 0.0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // chained rotations
    send(3.0);
    wait_valid();
    chk_bit("seq1_v", out_valid, 1'b1);
    chk_real("seq1_c", c_out, 0.0);
    chk_real("seq1_s", s_out, 1.0);
    chk_real("seq1_r", r_out, 3.0);
    send(4.0);
    wait_valid();
`ifndef PE_BOUNDARY_FORGET_EN
    chk_real("seq2_c", c_out, 0.6);
    chk_real("seq2_s", s_out, 0.8);
    chk_real("seq2_r", r_out, 5.0);
`endif
    send(-5.0);
    wait_valid();
`ifndef PE_BOUNDARY_FORGET_EN
    chk_real("seq3_c", c_out, 0.70710678);
    chk_real("seq3_s", s_out, -0.70710678);
    chk_real("seq3_r", r_out, 7.07106781);
`endif

    // zero vector
    clear_r();
    send(0.0);
    wait_valid();
    chk_bit("zero_v", out_valid, 1'b1);
    chk_real("zero_c", c_out, 1.0);
    chk_real("zero_s", s_out, 0.0);
    chk_real("zero_r", r_out, 0.0);
    cycle();
    chk_bit("zero_v_drop", out_valid, 1'b0);

    // backpressure, then back-to-back accept from HOLD
    clear_r();
    out_ready = 1'b0;
    send(3.0);
    wait_valid();
    repeat (5) cycle();
    chk_bit("bp_ready", in_ready, 1'b0);
    chk_real("bp_c", c_out, 0.0);
    chk_real("bp_r", r_out, 3.0);
    out_ready = 1'b1;
    in_valid = 1'b1;
    x_in = 1.0;
    #1;
    chk_bit("bp_ready_go", in_ready, 1'b1);
    cycle();
    in_valid = 1'b0;
    chk_bit("bp_v_drop", out_valid, 1'b0);
    wait_valid();
`ifndef PE_BOUNDARY_FORGET_EN
    chk_real("bp_r2", r_out, 3.16227766);
`endif

    // clear aborts an in-flight operation
    clear_r();
    send(3.0);
    wait_valid();
    in_valid = 1'b1;
    x_in = 1.0;
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();
    clr = 1'b1;
    in_valid = 1'b1;
    #1;
    chk_bit("clr_blocks", in_ready, 1'b0);
    cycle();
    clr = 1'b0;
    in_valid = 1'b0;
    chk_real("clr_r", r_out, 0.0);
    repeat (6) cycle();
    chk_bit("clr_no_v", out_valid, 1'b0);
    send(2.0);
    wait_valid();
    chk_real("clr2_c", c_out, 0.0);
    chk_real("clr2_s", s_out, 1.0);
    chk_real("clr2_r", r_out, 2.0);

    // forgetting factor
    clear_r();
    send(4.0);
    wait_valid();
    send(3.0);
    wait_valid();
`ifdef PE_BOUNDARY_FORGET_EN
    chk_real("fg_r", r_out, 3.60555128);
    chk_real("fg_c", c_out, 0.55470020);
    chk_real("fg_s", s_out, 0.83205029);
`else
    chk_real("fg_r", r_out, 5.0);
    chk_real("fg_c", c_out, 0.8);
    chk_real("fg_s", s_out, 0.6);
`endif

    // reset in the middle of an operation
    send(3.0);
    cycle();
    do_reset();

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      x_in      = real'(int'($urandom_range(0, 16)) - 8) / 2.0;
      out_ready = ($urandom_range(0, 9) < 7);
      clr       = ($urandom_range(0, 49) == 0);
      cycle();
      if (i % 400 == 399) do_reset();
    end
    clr = 1'b0;
    in_valid = 1'b0;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
